sd_otf_converter: RTL

Serial on-the-fly converter that takes the MSD-first signed-digit result stream of the radix-r online adders and assembles it into a two's-complement fixed-point word. It is the decode end of the redundant-digit path: tester operands are encoded as signed digits, and this block turns the adder output back into plain binary for result RAM writeback and host-side checking. It sits in the `pll_clock` domain, downstream of the adder output delay pipeline.

---
 rtl/sd_otf_converter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/sd_otf_converter.sv
// -----------------------------------------------------------------------------
// sd_otf_converter
//
// Serial on-the-fly converter for the MSD-first signed-digit result stream of
// the radix-RADIX online adders. Each accepted digit is folded into two
// running candidates:
//   q  - the word assembled so far, as a plain two's-complement integer
//   qm - the same word minus one unit in the last digit position
// A negative digit "borrows" from the prefix, which is exactly q - 1 = qm, so
// no carry ever has to ripple back through already-converted bits. After
// DIGITS digits q holds the finished word, which is presented in HOLD until
// the consumer takes it.
//
// Parameters
//   RADIX  - digit radix, power of two, >= 2
//   DIGITS - digits per word
//   K      - bits per digit magnitude, $clog2(RADIX)
//   DW     - digit width, K+1 (two's complement)
//   W      - output width, K*DIGITS+1
//
// Ports
//   pll_clock - the only clock, all state changes on its rising edge
//   resetn    - synchronous reset, active-low
//   in_valid  - in_digit carries a digit
//   in_ready  - converter accepts a digit this cycle (COLLECT)
//   in_digit  - signed digit, legal range -(RADIX-1)..RADIX-1; -RADIX is
//               an illegal code, converted as 0 and flagged in out_err
//   out_valid - converted word available (HOLD)
//   out_ready - consumer takes the word this cycle
//   out_value - two's-complement value of the word
//   out_err   - at least one illegal digit code was seen in this word
// -----------------------------------------------------------------------------
module sd_otf_converter #(
  parameter  int RADIX  = 2,
  parameter  int DIGITS = 15,
  localparam int K      = $clog2(RADIX),
  localparam int DW     = K + 1,
  localparam int W      = K * DIGITS + 1
) (
  input  logic          pll_clock,
  input  logic          resetn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_digit,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_value,
  output logic          out_err
);

  // Counter width; a one-digit word still needs a (constant zero) counter.
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [DW-1:0] ILLEGAL_CODE = {1'b1, {K{1'b0}}};
  localparam logic [CW-1:0] LAST_CNT     = CW'(DIGITS - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t state, state_next;

  logic [W-1:0]  q, qm;
  logic [CW-1:0] cnt;
  logic          err;

  // Decoded digit and candidate next values
  logic                 digit_illegal;
  logic signed [DW-1:0] d_eff;
  logic signed [DW-1:0] d_m1;
  logic                 d_neg, d_pos;
  logic [K-1:0]         q_low, qm_low;
  logic [W-1:0]         q_accept, qm_accept;

  // FSM strobes
  logic accept;
  logic consume;
  logic last_digit;

  // ---------------------------------------------------------------------------
  // Digit decode and on-the-fly append
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a value on every path (defaults
    // first, then overrides) so no latch can be inferred.
    digit_illegal = (in_digit == ILLEGAL_CODE);
    d_eff         = digit_illegal ? '0 : $signed(in_digit);
    d_m1          = d_eff - DW'(1);
    d_neg         = d_eff[DW-1];
    d_pos         = !d_neg && (d_eff != '0);

    // Appended digit bits are simply the low K bits taken modulo RADIX:
    //   d >= 0 : d          d < 0  : RADIX + d      (both = d mod RADIX)
    //   d >  0 : d - 1      d <= 0 : RADIX - 1 + d  (both = (d-1) mod RADIX)
    q_low  = d_eff[K-1:0];
    qm_low = d_m1[K-1:0];

    // Shift left by K, dropping bits above W, and append the new digit.
    q_accept  = d_neg ? {qm[W-K-1:0], q_low}  : {q[W-K-1:0], q_low};
    qm_accept = d_pos ? {q[W-K-1:0], qm_low}  : {qm[W-K-1:0], qm_low};
  end

  assign last_digit = (cnt == LAST_CNT);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge pll_clock) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!resetn) state <= COLLECT;
    else         state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs (decoded from state only, so there
  // is no combinational path from in_valid/out_ready to in_ready/out_valid)
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    consume    = 1'b0;

    unique case (state)
      COLLECT: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid && last_digit) state_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        consume   = out_ready;
        if (out_ready) state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge pll_clock) begin
    if (!resetn) begin
      // qm starts at all ones (-1): the empty prefix is 0, and 0 - 1 = -1, so
      // a leading negative digit borrows correctly.
      q   <= '0;
      qm  <= '1;
      cnt <= '0;
      err <= 1'b0;
    end else if (accept) begin
      q   <= q_accept;
      qm  <= qm_accept;
      err <= err | digit_illegal;
      cnt <= last_digit ? '0 : cnt + CW'(1);
    end else if (consume) begin
      q   <= '0;
      qm  <= '1;
      err <= 1'b0;
    end
  end

  assign out_value = q;
  assign out_err   = err;

endmodule
